counter_load_sequencer: RTL

Arbitrates parallel-load requests from N_REQ requesters onto the single LOAD/VALUE port of the 8-bit `counter` block.
- Serves requesters in round-robin order.
- Drives LOAD for a fixed number of cycles.
- Checks that the counter output C actually took the value.
- Returns a per-requester ACK, with ERR on mismatch.

Sits between software/config masters and the `counter` instance, on the counter's CLK domain.

---
 rtl/counter_ctrl_pkg.sv | 18 +
 rtl/counter_load_sequencer_if.sv | 33 +++
 rtl/counter_load_sequencer_rr_arbiter.sv | 38 +++
 rtl/counter_load_sequencer.sv | 116 +++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared types and helpers for the counter load sequencer.
// Imported by the interface, the arbiter and the sequencer top.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Index width that never collapses to zero bits, so a single requester
  // still gets a 1-bit grant id.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/counter_load_sequencer_if.sv
// Request/ack bus between the requesters, the sequencer and the counter.
// The master side is the environment: requesters plus the counter's C feedback.
interface counter_load_sequencer_if
  import counter_ctrl_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);

  localparam int GW = clog2_min1(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] value_in;
  logic [N_REQ-1:0]       ack;
  logic                   err;
  logic                   err_sticky;
  logic                   busy;
  logic [GW-1:0]          grant_id;
  logic                   load;
  logic [WIDTH-1:0]       value;
  logic [WIDTH-1:0]       c;

  modport master (
    output req, value_in, c,
    input  ack, err, err_sticky, busy, grant_id, load, value
  );

  modport slave (
    input  req, value_in, c,
    output ack, err, err_sticky, busy, grant_id, load, value
  );

endinterface

// File: rtl/counter_load_sequencer_rr_arbiter.sv
// Combinational round-robin pick: rotate the request vector so ptr sits at
// bit 0, take the lowest set bit, then rotate the index back.
module rr_arbiter
  import counter_ctrl_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int GW    = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    ptr,
  output logic             gnt_valid,
  output logic [GW-1:0]    gnt_id
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [GW-1:0]      offset;
  logic [GW:0]        id_sum;

  // ptr is always below N_REQ, so this window never runs off the end.
  assign req_dbl   = {req, req};
  assign req_rot   = req_dbl[ptr +: N_REQ];
  assign gnt_valid = |req_rot;

  always_comb begin
    offset = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) offset = GW'(i);
    end
  end

  always_comb begin
    id_sum = {1'b0, ptr} + {1'b0, offset};
    if (id_sum >= (GW + 1)'(N_REQ)) id_sum = id_sum - (GW + 1)'(N_REQ);
    gnt_id = id_sum[GW-1:0];
  end

endmodule

// File: rtl/counter_load_sequencer.sv
// Serialises parallel-load requests onto the counter's LOAD/VALUE port,
// verifies the counter took the value and acks the requester.
module counter_load_sequencer
  import counter_ctrl_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 8,
  parameter int LOAD_CYCLES = 2,
  parameter int CHECK_EN    = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  counter_load_sequencer_if.slave bus
);

  localparam int GW  = clog2_min1(N_REQ);
  localparam int LCW = clog2_min1(LOAD_CYCLES);

  state_t             state_reg;
  logic [LCW-1:0]     load_cnt_reg;
  logic [GW-1:0]      ptr_reg;
  logic [GW-1:0]      ptr_next;
  logic [GW-1:0]      grant_id_reg;
  logic [WIDTH-1:0]   value_reg;
  logic               load_reg;
  logic               busy_reg;
  logic [N_REQ-1:0]   ack_reg;
  logic               err_reg;
  logic               err_sticky_reg;

  logic               gnt_valid;
  logic [GW-1:0]      gnt_id;
  logic [WIDTH-1:0]   gnt_value;
  logic               check_fail;
  logic [WIDTH-1:0]   value_slice [N_REQ];

  rr_arbiter #(
    .N_REQ (N_REQ),
    .GW    (GW)
  ) u_arb (
    .req       (bus.req),
    .ptr       (ptr_reg),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign value_slice[gi] = bus.value_in[gi*WIDTH +: WIDTH];
  end

  assign gnt_value  = value_slice[gnt_id];
  // The counter only starts incrementing at the end of CHECK, so C must
  // still hold exactly what was loaded.
  assign check_fail = (CHECK_EN != 0) && (bus.c != value_reg);
  assign ptr_next   = (grant_id_reg == GW'(N_REQ - 1)) ? '0 : grant_id_reg + GW'(1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      load_cnt_reg   <= '0;
      ptr_reg        <= '0;
      grant_id_reg   <= '0;
      value_reg      <= '0;
      load_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      ack_reg        <= '0;
      err_reg        <= 1'b0;
      err_sticky_reg <= 1'b0;
    end else begin
      ack_reg <= '0;
      err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (gnt_valid) begin
            grant_id_reg <= gnt_id;
            value_reg    <= gnt_value;
            load_cnt_reg <= LCW'(LOAD_CYCLES - 1);
            load_reg     <= 1'b1;
            busy_reg     <= 1'b1;
            state_reg    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (load_cnt_reg == '0) begin
            load_reg  <= 1'b0;
            state_reg <= ST_CHECK;
          end else begin
            load_cnt_reg <= load_cnt_reg - LCW'(1);
          end
        end
        ST_CHECK: begin
          // ACK/ERR are registered here so they are visible during DONE.
          ack_reg[grant_id_reg] <= 1'b1;
          err_reg               <= check_fail;
          err_sticky_reg        <= err_sticky_reg | check_fail;
          state_reg             <= ST_DONE;
        end
        ST_DONE: begin
          ptr_reg   <= ptr_next;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.ack        = ack_reg;
  assign bus.err        = err_reg;
  assign bus.err_sticky = err_sticky_reg;
  assign bus.busy       = busy_reg;
  assign bus.grant_id   = grant_id_reg;
  assign bus.load       = load_reg;
  assign bus.value      = value_reg;

endmodule
